// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x3 keypad scanner: FSM states, matrix geometry
// and the row/column to key-code map.
package keypad_pkg;

    typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} kp_state_e;

    localparam int unsigned NUM_ROWS = 4;
    localparam int unsigned NUM_COLS = 3;
    localparam logic [3:0]  KEY_STAR = 4'd10;
    localparam logic [3:0]  KEY_HASH = 4'd11;

    localparam logic [3:0] KEY_MAP [NUM_ROWS][NUM_COLS] = '{
        '{4'd1,     4'd2, 4'd3    },
        '{4'd4,     4'd5, 4'd6    },
        '{4'd7,     4'd8, 4'd9    },
        '{KEY_STAR, 4'd0, KEY_HASH}
    };

    function automatic logic single_low(input logic [NUM_ROWS-1:0] rows);
        return $countones(~rows) == 1;
    endfunction

    function automatic logic [1:0] low_index(input logic [NUM_ROWS-1:0] rows);
        logic [1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_ROWS; i++) begin
            if (!rows[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// Scan divider: free-running 0..SCAN_DIV-1 counter, tick high on the terminal count.
module keypad_tick_gen #(
    parameter int unsigned SCAN_DIV = 1000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int unsigned CW = $clog2(SCAN_DIV);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == CW'(SCAN_DIV - 1));

    always_comb begin
        cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/keypad_scan_encoder.sv
// 4x3 keypad scanner with press/release debounce, producing registered one-hot decimal
// lines, a key code, */# flags, a held level and a one-clock accept strobe.
module keypad_scan_encoder
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 1000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  row_n,
    output logic [2:0]  col_n,
    output logic [9:0]  dec_onehot,
    output logic [3:0]  key_code,
    output logic        key_star,
    output logic        key_hash,
    output logic        key_held,
    output logic        key_valid
);

    localparam int unsigned      DW      = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0]    DBC_MAX = DW'(DEBOUNCE_SCANS);
    localparam logic [DW-1:0]    DBC_ONE = DW'(1);

    logic            tick;
    logic [3:0]      rs_meta_q, rs_q;
    kp_state_e       state_q, state_d;
    logic [DW-1:0]   dbc_q, dbc_d, dbc_inc;
    logic [1:0]      col_q, col_d, col_next;
    logic [1:0]      row_q, row_d;
    logic            col_match, accept, release_done;
    logic [3:0]      key_sel;
    logic [9:0]      dec_q, dec_d;
    logic [3:0]      code_q, code_d;
    logic            star_q, star_d, hash_q, hash_d;
    logic            held_q, held_d, valid_q, valid_d;

    keypad_tick_gen #(
        .SCAN_DIV(SCAN_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs_meta_q <= 4'b1111;
            rs_q      <= 4'b1111;
        end else begin
            rs_meta_q <= row_n;
            rs_q      <= rs_meta_q;
        end
    end

    assign col_next  = (col_q == 2'd2) ? 2'd0 : col_q + 2'd1;
    assign col_match = (rs_q == ~(4'b0001 << row_q));
    assign dbc_inc   = (dbc_q >= DBC_MAX) ? dbc_q : dbc_q + DBC_ONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SCAN;
            dbc_q   <= '0;
            col_q   <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            dbc_q   <= dbc_d;
            col_q   <= col_d;
            row_q   <= row_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        dbc_d        = dbc_q;
        col_d        = col_q;
        row_d        = row_q;
        accept       = 1'b0;
        release_done = 1'b0;
        if (tick) begin
            unique case (state_q)
                SCAN: begin
                    if (single_low(rs_q)) begin
                        row_d = low_index(rs_q);
                        dbc_d = DBC_ONE;
                        if (DBC_ONE >= DBC_MAX) begin
                            state_d = PRESSED;
                            accept  = 1'b1;
                        end else begin
                            state_d = DEBOUNCE;
                        end
                    end else begin
                        col_d = col_next;
                    end
                end
                DEBOUNCE: begin
                    if (col_match) begin
                        dbc_d = dbc_inc;
                        if (dbc_inc >= DBC_MAX) begin
                            state_d = PRESSED;
                            accept  = 1'b1;
                        end
                    end else begin
                        state_d = SCAN;
                        col_d   = col_next;
                    end
                end
                PRESSED: begin
                    if (&rs_q) begin
                        dbc_d = DBC_ONE;
                        if (DBC_ONE >= DBC_MAX) begin
                            state_d      = SCAN;
                            col_d        = col_next;
                            release_done = 1'b1;
                        end else begin
                            state_d = RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    if (&rs_q) begin
                        dbc_d = dbc_inc;
                        if (dbc_inc >= DBC_MAX) begin
                            state_d      = SCAN;
                            col_d        = col_next;
                            release_done = 1'b1;
                        end
                    end else begin
                        dbc_d = '0;
                    end
                end
                default: state_d = SCAN;
            endcase
        end
    end

    // row_d is used so a single-scan debounce can accept on the detection tick itself
    always_comb begin
        key_sel = KEY_MAP[row_d][col_q];
        dec_d   = dec_q;
        code_d  = code_q;
        star_d  = star_q;
        hash_d  = hash_q;
        held_d  = held_q;
        valid_d = accept;
        if (accept) begin
            code_d = key_sel;
            dec_d  = (key_sel <= 4'd9) ? (10'd1 << key_sel) : 10'd0;
            star_d = (key_sel == KEY_STAR);
            hash_d = (key_sel == KEY_HASH);
            held_d = 1'b1;
        end else if (release_done) begin
            code_d = '0;
            dec_d  = '0;
            star_d = 1'b0;
            hash_d = 1'b0;
            held_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_q   <= '0;
            code_q  <= '0;
            star_q  <= 1'b0;
            hash_q  <= 1'b0;
            held_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            dec_q   <= dec_d;
            code_q  <= code_d;
            star_q  <= star_d;
            hash_q  <= hash_d;
            held_q  <= held_d;
            valid_q <= valid_d;
        end
    end

    assign col_n      = ~(3'b001 << col_q);
    assign dec_onehot = dec_q;
    assign key_code   = code_q;
    assign key_star   = star_q;
    assign key_hash   = hash_q;
    assign key_held   = held_q;
    assign key_valid  = valid_q;

endmodule
